// File: rtl/en_delay_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : en_delay_pkg                                                 |
// | Description : Shared defaults and width helper for the enabled delay line. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package en_delay_pkg;

    localparam int c_DEFAULT_WIDTH = 8;
    localparam int c_DEFAULT_DEPTH = 4;

    // Bits needed to hold every value 0..depth inclusive.
    function automatic int clog2_cnt(input int depth);
        int w;
        w = 0;
        while ((1 << w) < (depth + 1)) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/en_dff_w.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : en_dff_w                                                     |
// | Description : WIDTH-bit register, sync reset, parallel load over enable.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module en_dff_w #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= load_value;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/en_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : en_delay_line                                                |
// | Description : WIDTH x DEPTH enabled delay line with valid chain and fill.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module en_delay_line
    import en_delay_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int DEPTH = c_DEFAULT_DEPTH,
    parameter int CNT_W = clog2_cnt(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [WIDTH-1:0]       d,
    input  logic                   load,
    input  logic [WIDTH*DEPTH-1:0] load_data,
    input  logic                   flush,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic [CNT_W-1:0]       fill_count,
    output logic                   full
);

    localparam logic [CNT_W-1:0] c_FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [DEPTH-1:0] c_VLD_FIRST  = DEPTH'(1);
    localparam logic [DEPTH-1:0] c_VLD_ALL    = '1;

    logic [WIDTH-1:0] w_stage [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [CNT_W-1:0] r_count;
    logic [DEPTH-1:0] w_vld_shift;

    // Flush only touches the valid bookkeeping, so the data stages see en unchanged.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic [WIDTH-1:0] w_stage_in;
            if (i == 0) begin : g_head
                assign w_stage_in = d;
            end else begin : g_tail
                assign w_stage_in = w_stage[i-1];
            end

            en_dff_w #(
                .WIDTH(WIDTH)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .en        (en),
                .load      (load),
                .d         (w_stage_in),
                .load_value(load_data[i*WIDTH +: WIDTH]),
                .q         (w_stage[i])
            );
        end
    endgenerate

    // Dropping the top bit of {vld,1} handles DEPTH=1 without a zero-width slice.
    assign w_vld_shift = DEPTH'({r_vld, 1'b1});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld   <= '0;
            r_count <= '0;
        end else if (load) begin
            r_vld   <= c_VLD_ALL;
            r_count <= c_FULL_COUNT;
        end else if (flush) begin
            if (en) begin
                r_vld   <= c_VLD_FIRST;
                r_count <= CNT_W'(1);
            end else begin
                r_vld   <= '0;
                r_count <= '0;
            end
        end else if (en) begin
            r_vld <= w_vld_shift;
            if (r_count != c_FULL_COUNT) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign q          = w_stage[DEPTH-1];
    assign q_valid    = r_vld[DEPTH-1];
    assign fill_count = r_count;
    assign full       = (r_count == c_FULL_COUNT);

endmodule
`default_nettype wire

// File: tb/tb_en_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_en_delay_line                                             |
// | Description : Scoreboard bench for en_delay_line (8x4 and 1x1 instances).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_en_delay_line;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic                   clk;
    logic                   rst;
    logic                   en;
    logic [WIDTH-1:0]       d;
    logic                   load;
    logic [WIDTH*DEPTH-1:0] load_data;
    logic                   flush;
    logic [WIDTH-1:0]       q;
    logic                   q_valid;
    logic [CNT_W-1:0]       fill_count;
    logic                   full;

    logic s_en;
    logic s_d;
    logic s_q;
    logic s_q_valid;
    logic s_fill_count;
    logic s_full;

    int errors = 0;
    int checks = 0;
    int mcount = 0;
    bit inv_on = 0;
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] exp_q;

    en_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .d         (d),
        .load      (load),
        .load_data (load_data),
        .flush     (flush),
        .q         (q),
        .q_valid   (q_valid),
        .fill_count(fill_count),
        .full      (full)
    );

    en_delay_line #(.WIDTH(1), .DEPTH(1)) dut_small (
        .clk       (clk),
        .rst       (rst),
        .en        (s_en),
        .d         (s_d),
        .load      (1'b0),
        .load_data (1'b0),
        .flush     (1'b0),
        .q         (s_q),
        .q_valid   (s_q_valid),
        .fill_count(s_fill_count),
        .full      (s_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fill_count must equal popcount of the valid chain, and valid stages must be a prefix.
    always @(negedge clk) begin
        if (inv_on) begin
            checks++;
            if ((fill_count !== CNT_W'($countones(dut.r_vld))) ||
                ((dut.r_vld & (dut.r_vld + 4'd1)) !== 4'd0)) begin
                errors++;
                $display("FAIL invariant: vld=%b fill_count=%0d", dut.r_vld, fill_count);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; d = 8'hFF; s_en = 1'b1; s_d = 1'b1;
        tick();
        tick();
        checks++;
        if ({q, q_valid, fill_count, full} !== {8'h00, 1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset: q=%h qv=%b cnt=%0d full=%b, want 00 0 0 0", q, q_valid, fill_count, full);
        end
        checks++;
        if ({s_q, s_q_valid, s_fill_count, s_full} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_small: got %b want 0000", {s_q, s_q_valid, s_fill_count, s_full});
        end
        rst = 1'b0; en = 1'b0; s_en = 1'b0; s_d = 1'b0;
        mcount = 0;
        sb.delete();
        inv_on = 1'b1;
    endtask

    // One edge with the given enable; scoreboard pops once DEPTH samples are in flight.
    task automatic stream_edge(input logic e, input logic [WIDTH-1:0] v);
        en = e; d = v;
        if (e) begin
            sb.push_back(v);
            if (mcount < DEPTH) mcount++;
        end
        tick();
        checks++;
        if (fill_count !== CNT_W'(mcount)) begin
            errors++;
            $display("FAIL fill_count: got %0d want %0d", fill_count, mcount);
        end
        if (sb.size() == DEPTH) begin
            exp_q = sb.pop_front();
            checks++;
            if ({q, q_valid, full} !== {exp_q, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL stream_q: q=%h qv=%b full=%b want %h 1 1", q, q_valid, full, exp_q);
            end
        end else begin
            checks++;
            if ({q_valid, full} !== 2'b00) begin
                errors++;
                $display("FAIL stream_notvalid: qv=%b full=%b want 0 0", q_valid, full);
            end
        end
    endtask

    task automatic test_fill_stream();
        logic [WIDTH-1:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) stream_edge(1'b1, vals[i]);
        en = 1'b0;
    endtask

    task automatic test_gapped();
        logic [WIDTH-1:0] vals [7] = '{8'hA1, 8'hEE, 8'hA2, 8'hEE, 8'hA3, 8'hEE, 8'hA4};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mcount = 0;
        sb.delete();
        for (int i = 0; i < 7; i++) stream_edge((i % 2) == 0, vals[i]);
        // Draining with more enabled edges exposes A2..A4 and proves no EE was captured.
        for (int i = 0; i < 3; i++) stream_edge(1'b1, 8'h00);
        en = 1'b0;
    endtask

    task automatic test_load();
        load = 1'b1; en = 1'b1; d = 8'h77; load_data = 32'h44332211;
        tick();
        checks++;
        if ({q, q_valid, fill_count, full} !== {8'h44, 1'b1, 3'd4, 1'b1}) begin
            errors++;
            $display("FAIL load: q=%h qv=%b cnt=%0d full=%b want 44 1 4 1", q, q_valid, fill_count, full);
        end
        load = 1'b0; en = 1'b1; d = 8'h99;
        tick();
        checks++;
        if ({q, q_valid, fill_count} !== {8'h33, 1'b1, 3'd4}) begin
            errors++;
            $display("FAIL load_shift: q=%h qv=%b cnt=%0d want 33 1 4", q, q_valid, fill_count);
        end
        en = 1'b0;
    endtask

    task automatic test_flush();
        load = 1'b1; load_data = 32'h44332211;
        tick();
        load = 1'b0; flush = 1'b1; en = 1'b0; d = 8'hEE;
        tick();
        checks++;
        if ({q, q_valid, fill_count, full} !== {8'h44, 1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL flush_hold: q=%h qv=%b cnt=%0d full=%b want 44 0 0 0", q, q_valid, fill_count, full);
        end
        en = 1'b1; d = 8'h5A;
        tick();
        checks++;
        if ({q, q_valid, fill_count, full} !== {8'h33, 1'b0, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL flush_shift: q=%h qv=%b cnt=%0d full=%b want 33 0 1 0", q, q_valid, fill_count, full);
        end
        flush = 1'b0; en = 1'b1; d = 8'h6B;
        tick();
        checks++;
        if (fill_count !== 3'd2) begin
            errors++;
            $display("FAIL flush_refill: cnt=%0d want 2", fill_count);
        end
        en = 1'b0;
    endtask

    task automatic test_reset_priority();
        rst = 1'b1; load = 1'b1; flush = 1'b1; en = 1'b1; d = 8'hFF; load_data = '1;
        tick();
        checks++;
        if ({q, q_valid, fill_count, full} !== {8'h00, 1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_priority: q=%h qv=%b cnt=%0d full=%b want 00 0 0 0", q, q_valid, fill_count, full);
        end
        rst = 1'b0; load = 1'b0; flush = 1'b0; en = 1'b0; load_data = '0;
    endtask

    task automatic test_degenerate();
        s_en = 1'b1; s_d = 1'b1;
        tick();
        checks++;
        if ({s_q, s_q_valid, s_fill_count, s_full} !== 4'b1111) begin
            errors++;
            $display("FAIL small_capture: got %b want 1111", {s_q, s_q_valid, s_fill_count, s_full});
        end
        s_en = 1'b0; s_d = 1'b0;
        tick();
        checks++;
        if ({s_q, s_full} !== 2'b11) begin
            errors++;
            $display("FAIL small_hold: q=%b full=%b want 1 1", s_q, s_full);
        end
        s_en = 1'b1; s_d = 1'b0;
        tick();
        checks++;
        if ({s_q, s_full} !== 2'b01) begin
            errors++;
            $display("FAIL small_follow: q=%b full=%b want 0 1", s_q, s_full);
        end
        s_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; d = '0; load = 1'b0; load_data = '0; flush = 1'b0;
        s_en = 1'b0; s_d = 1'b0;
        test_reset();
        test_fill_stream();
        test_gapped();
        test_load();
        test_flush();
        test_reset_priority();
        test_degenerate();
        inv_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/en_delay_line.md
Name: en_delay_line

Overview:
- Parametrised successor to the single-bit enabled D flip-flop.
- A WIDTH-bit, DEPTH-stage delay line that advances only on enabled clock edges.
- Adds per-stage valid tracking, parallel load, flush and a fill counter.
- Used as the generic enabled pipeline/delay primitive in lab datapaths; DEPTH=1, WIDTH=1 reduces to the plain enabled flop.

Parameters:
- WIDTH, 8, data width of each stage (>=1)
- DEPTH, 4, number of stages (>=1)
- CNT_W, $clog2(DEPTH+1), width of fill_count (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  shift enable; one stage advance per enabled edge
- d  input  WIDTH  serial input, captured into stage 0
- load  input  1  parallel load of all stages
- load_data  input  WIDTH*DEPTH  slice i ([i*WIDTH +: WIDTH]) loads stage i
- flush  input  1  invalidate contents (valid bits and count only)
- q  output  WIDTH  contents of stage DEPTH-1
- q_valid  output  1  valid bit of stage DEPTH-1
- fill_count  output  CNT_W  number of valid stages, 0..DEPTH
- full  output  1  fill_count == DEPTH

Behaviour:
- All state updates on posedge clk. One clock, no async logic.
- Outputs are direct register outputs: q = stage[DEPTH-1], q_valid = vld[DEPTH-1]. No combinational input-to-output path.
- Priority, evaluated each edge: rst > load > flush > en > hold.
- rst=1:
  - all stages = 0, all vld = 0, fill_count = 0
  - hence q=0, q_valid=0, full=0
  - rst overrides load, flush and en in the same cycle
- load=1 (rst=0):
  - stage[i] <= load_data slice i, all vld <= 1, fill_count <= DEPTH
  - en and flush ignored that cycle
- flush=1 (rst=0, load=0), en=0:
  - all vld <= 0, fill_count <= 0
  - stage data retained, so q holds its value and q_valid=0
- flush=1 with en=1:
  - data shifts normally
  - vld <= {0...0,1} (only stage 0 valid), fill_count <= 1
- en=1 (no rst/load/flush):
  - stage[0] <= d; stage[i] <= stage[i-1] for i=1..DEPTH-1
  - vld shifts likewise with 1 entering vld[0]
  - fill_count <= min(fill_count+1, DEPTH), saturating, never wraps
- en=0 (no rst/load/flush): every register holds; d is ignored.
- Latency: a sample taken on enabled edge k appears on q after the DEPTH-th enabled edge counted from k inclusive. Disabled edges add no stages.
- Invariant: fill_count always equals popcount(vld), and the valid stages are contiguous from stage 0. A bench assertion checks both.
- DEPTH=1: q follows d one enabled edge later; fill_count is 1 bit.
- Mid-operation reset: any partial fill is lost and the sequence restarts from empty.
- Unknowns: d or load_data X is allowed while not captured. en, load, flush and rst must be known after the first clock.

Decomposition:
- Package en_delay_pkg:
  - function clog2_cnt(depth) for CNT_W
  - localparams for the default WIDTH/DEPTH
- Sub-module en_dff_w (WIDTH-bit register with sync rst, en, load and load value), instantiated DEPTH times via generate.
- Valid chain and fill counter stay in the top module.

Test Plan:
All cases use WIDTH=8, DEPTH=4 unless stated.
1. Reset: rst=1 for 2 edges with en=1, d=0xFF -> q=0x00, q_valid=0, fill_count=0, full=0.
2. Fill and stream: en=1, d=0x11,0x22,0x33,0x44,0x55 on consecutive edges
   - fill_count goes 1,2,3,4,4
   - after the 4th edge: q=0x11, q_valid=1, full=1
   - after the 5th edge: q=0x22
3. Gapped enable: en=1,0,1,0,1,0,1 with d=0xA1,0xEE,0xA2,0xEE,0xA3,0xEE,0xA4
   - after the last edge: q=0xA1, fill_count=4
   - no 0xEE value is ever captured
4. Parallel load: load=1, en=1, load_data=0x44332211
   - next edge: q=0x44, q_valid=1, fill_count=4, full=1 (load beats en)
   - then one en edge with d=0x99: q=0x33
5. Flush: starting full with q=0x44
   - flush=1, en=0 -> q=0x44 held, q_valid=0, fill_count=0
   - next, flush=1, en=1, d=0x5A -> fill_count=1, q_valid=0
6. Reset priority and degenerate case:
   - rst=1 together with load=1, flush=1, en=1 -> all outputs 0
   - a separate WIDTH=1, DEPTH=1 instance with en=1, d=1 -> q=1 and full=1 after one edge; en=0, d=0 -> q stays 1
